// File: rtl/operand_entry_ctrl.sv
// Pushbutton operand entry: debounces four buttons and sequences OPCODE -> A -> B -> SEND,
// then offers the operation on a valid/ready handshake. Optional macro AUTOREPEAT_EN adds hold-to-repeat on BTNU/BTND.
module operand_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 30000000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       BTNC,
    input  logic       BTNL,
    input  logic       BTNU,
    input  logic       BTND,
    output logic [2:0] OPCODE,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [1:0] FIELD_SEL,
    output logic       OP_VALID,
    input  logic       OP_READY
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        EDIT_OP = 2'd0,
        EDIT_A  = 2'd1,
        EDIT_B  = 2'd2,
        SEND    = 2'd3
    } state_t;

    // Button vector order: [3]=BTNC, [2]=BTNL, [1]=BTNU, [0]=BTND
    logic [3:0]      raw;
    logic [3:0]      sync_p0;
    logic [3:0]      sync_p1;
    logic [3:0]      level;
    logic [3:0]      level_p2;
    logic [3:0]      press_p3;
    logic [DB_W-1:0] db_cnt [4];

    logic [1:0]      rst_sync;
    logic            rst_n;

    state_t          state;
    state_t          state_nx;
    logic [2:0]      opcode_q;
    logic [2:0]      opcode_nx;
    logic [3:0]      a_q;
    logic [3:0]      a_nx;
    logic [3:0]      b_q;
    logic [3:0]      b_nx;
    logic            rep_up;
    logic            rep_dn;
    logic            up_req;
    logic            dn_req;

    function automatic logic [2:0] step3(input logic [2:0] v, input logic up);
        return up ? v + 3'd1 : v - 3'd1;
    endfunction

    function automatic logic [3:0] step4(input logic [3:0] v, input logic up);
        return up ? v + 4'd1 : v - 4'd1;
    endfunction

    // Reset asserts asynchronously and releases two clocks after CPU_RESETN rises
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) rst_sync <= 2'b00;
        else             rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign raw = {BTNC, BTNL, BTNU, BTND};

    // p0/p1: synchronizer, level: debounced, p2/p3: rising-edge press pulse
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            level    <= '0;
            level_p2 <= '0;
            press_p3 <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync_p0  <= raw;
            sync_p1  <= sync_p0;
            level_p2 <= level;
            press_p3 <= level & ~level_p2;
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync_p1[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

    logic [RP_W-1:0] rep_cnt;
    logic            held;

    // Repeat pulses are registered so they line up one step per REPEAT_CYCLES after the press step
    assign held = (level_p2[1] | level_p2[0]) && (state != SEND) && (state_nx == state);

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
            rep_up  <= 1'b0;
            rep_dn  <= 1'b0;
        end else begin
            rep_up <= 1'b0;
            rep_dn <= 1'b0;
            if (!held) begin
                rep_cnt <= '0;
            end else if (rep_cnt == RP_LAST) begin
                rep_cnt <= '0;
                rep_up  <= level_p2[1];
                rep_dn  <= ~level_p2[1];
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end
`else
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    assign up_req = press_p3[1] | rep_up;
    assign dn_req = press_p3[0] | rep_dn;

    // Only one action per cycle: BTNC > BTNL > BTNU > BTND
    always_comb begin
        state_nx  = state;
        opcode_nx = opcode_q;
        a_nx      = a_q;
        b_nx      = b_q;
        if (state == SEND) begin
            if (OP_READY) state_nx = EDIT_OP;
        end else if (press_p3[3]) begin
            case (state)
                EDIT_OP: state_nx = (opcode_q == 3'd0) ? SEND : EDIT_A;
                EDIT_A:  state_nx = (opcode_q == 3'd1) ? SEND : EDIT_B;
                default: state_nx = SEND;
            endcase
        end else if (press_p3[2]) begin
            if (state == EDIT_A)      state_nx = EDIT_OP;
            else if (state == EDIT_B) state_nx = EDIT_A;
        end else if (up_req || dn_req) begin
            case (state)
                EDIT_OP: opcode_nx = step3(opcode_q, up_req);
                EDIT_A:  a_nx      = step4(a_q, up_req);
                default: b_nx      = step4(b_q, up_req);
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EDIT_OP;
            opcode_q <= 3'd0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
        end else begin
            state    <= state_nx;
            opcode_q <= opcode_nx;
            a_q      <= a_nx;
            b_q      <= b_nx;
        end
    end

    assign OPCODE    = opcode_q;
    assign A         = a_q;
    assign B         = b_q;
    assign FIELD_SEL = state;
    assign OP_VALID  = (state == SEND);

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Scoreboard bench for operand_entry_ctrl: stimulus queues expected snapshots and transfers,
// a negedge monitor pops and compares them against the outputs.
module tb_operand_entry_ctrl;

`ifdef AUTOREPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'b0;
    logic       op_ready = 1'b0;
    logic [2:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] field_sel;
    logic       op_valid;

    int vectors = 0;
    int miscompares = 0;
    logic seen_b = 1'b0;

    typedef struct {
        string      tag;
        logic [2:0] op;
        logic [3:0] av;
        logic [3:0] bv;
        logic [1:0] fs;
        logic       v;
    } snap_t;

    typedef struct {
        logic [2:0] op;
        logic [3:0] av;
        logic [3:0] bv;
    } txn_t;

    snap_t snap_q[$];
    txn_t  txn_q[$];

    operand_entry_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_CYCLES  (20)
    ) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .BTNC      (btn[3]),
        .BTNL      (btn[2]),
        .BTNU      (btn[1]),
        .BTND      (btn[0]),
        .OPCODE    (opcode),
        .A         (a),
        .B         (b),
        .FIELD_SEL (field_sel),
        .OP_VALID  (op_valid),
        .OP_READY  (op_ready)
    );

    always #5 clk = ~clk;

    function automatic void cmp_snap(snap_t e);
        vectors++;
        if (opcode !== e.op || a !== e.av || b !== e.bv || field_sel !== e.fs || op_valid !== e.v) begin
            miscompares++;
            $display("FAIL %s: got op=%0d a=%h b=%h sel=%0d vld=%b, want op=%0d a=%h b=%h sel=%0d vld=%b",
                     e.tag, opcode, a, b, field_sel, op_valid, e.op, e.av, e.bv, e.fs, e.v);
        end
    endfunction

    always @(negedge clk) begin
        while (snap_q.size() > 0) cmp_snap(snap_q.pop_front());
        if (field_sel == 2'd2) seen_b = 1'b1;
        if (op_valid && op_ready) begin
            vectors++;
            if (txn_q.size() == 0) begin
                miscompares++;
                $display("FAIL txn: unexpected transfer op=%0d a=%h b=%h, want none", opcode, a, b);
            end else begin
                txn_t t;
                t = txn_q.pop_front();
                if (opcode !== t.op || a !== t.av || b !== t.bv) begin
                    miscompares++;
                    $display("FAIL txn: got op=%0d a=%h b=%h, want op=%0d a=%h b=%h",
                             opcode, a, b, t.op, t.av, t.bv);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_snap(input string tag, input logic [2:0] op, input logic [3:0] av,
                               input logic [3:0] bv, input logic [1:0] fs, input logic v);
        snap_t e;
        e.tag = tag; e.op = op; e.av = av; e.bv = bv; e.fs = fs; e.v = v;
        snap_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic push_txn(input logic [2:0] op, input logic [3:0] av, input logic [3:0] bv);
        txn_t t;
        t.op = op; t.av = av; t.bv = bv;
        txn_q.push_back(t);
    endtask

    // Clean press: hold 10 cycles then release 10; the action lands 8 edges after the press
    task automatic press(input logic [3:0] mask, input int n = 1);
        for (int i = 0; i < n; i++) begin
            tick(1);
            btn = mask;
            tick(10);
            btn = 4'b0;
            tick(10);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: end of test not reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(5);
        expect_snap("reset", 3'd0, 4'h0, 4'h0, 2'd0, 1'b0);

        // Bouncy BTNU then a clean edge: one increment, 8 edges after the edge
        tick(1);
        for (int i = 0; i < 3; i++) begin
            btn = 4'b0010; tick(2);
            btn = 4'b0000; tick(2);
        end
        btn = 4'b0010;
        tick(7);
        expect_snap("debounce_before", 3'd0, 4'h0, 4'h0, 2'd0, 1'b0);
        tick(1);
        expect_snap("debounce_once", 3'd1, 4'h0, 4'h0, 2'd0, 1'b0);
        tick(3);
        btn = 4'b0;
        tick(10);

        press(4'b0001);
        expect_snap("dec_to_zero", 3'd0, 4'h0, 4'h0, 2'd0, 1'b0);
        press(4'b0001);
        expect_snap("dec_wrap", 3'd7, 4'h0, 4'h0, 2'd0, 1'b0);
        press(4'b0010);
        expect_snap("inc_wrap", 3'd0, 4'h0, 4'h0, 2'd0, 1'b0);

        // Full entry: OPCODE=7, A=D, B=3
        press(4'b0001);
        press(4'b1000);
        expect_snap("enter_a", 3'd7, 4'h0, 4'h0, 2'd1, 1'b0);
        press(4'b0001, 3);
        expect_snap("a_dec_wrap", 3'd7, 4'hD, 4'h0, 2'd1, 1'b0);
        press(4'b1000);
        press(4'b0010, 3);
        expect_snap("b_set", 3'd7, 4'hD, 4'h3, 2'd2, 1'b0);
        push_txn(3'd7, 4'hD, 4'h3);
        press(4'b1000);
        expect_snap("send_hold", 3'd7, 4'hD, 4'h3, 2'd3, 1'b1);
        tick(5);
        expect_snap("send_stable", 3'd7, 4'hD, 4'h3, 2'd3, 1'b1);
        press(4'b0010);
        expect_snap("send_ignores", 3'd7, 4'hD, 4'h3, 2'd3, 1'b1);
        tick(1);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        expect_snap("after_accept", 3'd7, 4'hD, 4'h3, 2'd0, 1'b0);

        // Unary opcode skips B
        press(4'b0010, 2);
        expect_snap("op_unary", 3'd1, 4'hD, 4'h3, 2'd0, 1'b0);
        seen_b = 1'b0;
        press(4'b1000);
        press(4'b0010, 8);
        expect_snap("unary_a", 3'd1, 4'h5, 4'h3, 2'd1, 1'b0);
        push_txn(3'd1, 4'h5, 4'h3);
        press(4'b1000);
        expect_snap("unary_send", 3'd1, 4'h5, 4'h3, 2'd3, 1'b1);
        vectors++;
        if (seen_b !== 1'b0) begin
            miscompares++;
            $display("FAIL unary_no_b: got sel=2 seen=%b, want seen=0", seen_b);
        end
        tick(1);
        op_ready = 1'b1;
        tick(1);
        op_ready = 1'b0;
        expect_snap("unary_done", 3'd1, 4'h5, 4'h3, 2'd0, 1'b0);

        // Opcode 0 goes straight to SEND; READY already high completes at once
        press(4'b0001);
        expect_snap("op_nop", 3'd0, 4'h5, 4'h3, 2'd0, 1'b0);
        op_ready = 1'b1;
        push_txn(3'd0, 4'h5, 4'h3);
        press(4'b1000);
        op_ready = 1'b0;
        expect_snap("nop_done", 3'd0, 4'h5, 4'h3, 2'd0, 1'b0);

        // Coincident BTNC+BTNU, then BTNL navigation
        press(4'b0010, 2);
        press(4'b1000);
        press(4'b0001, 3);
        expect_snap("a_is_2", 3'd2, 4'h2, 4'h3, 2'd1, 1'b0);
        press(4'b1010);
        expect_snap("c_beats_u", 3'd2, 4'h2, 4'h3, 2'd2, 1'b0);
        press(4'b0100);
        expect_snap("back_to_a", 3'd2, 4'h2, 4'h3, 2'd1, 1'b0);
        press(4'b0100);
        expect_snap("back_to_op", 3'd2, 4'h2, 4'h3, 2'd0, 1'b0);
        press(4'b0100);
        expect_snap("back_in_op", 3'd2, 4'h2, 4'h3, 2'd0, 1'b0);

        // Hold BTNU in EDIT_A from A=E
        press(4'b1000);
        press(4'b0001, 4);
        expect_snap("a_is_e", 3'd2, 4'hE, 4'h3, 2'd1, 1'b0);
        tick(1);
        btn = 4'b0010;
        tick(8);
        expect_snap("hold_first", 3'd2, 4'hF, 4'h3, 2'd1, 1'b0);
        tick(19);
        expect_snap("hold_wait", 3'd2, 4'hF, 4'h3, 2'd1, 1'b0);
        tick(1);
        expect_snap("hold_rep1", 3'd2, REP ? 4'h0 : 4'hF, 4'h3, 2'd1, 1'b0);
        tick(20);
        expect_snap("hold_rep2", 3'd2, REP ? 4'h1 : 4'hF, 4'h3, 2'd1, 1'b0);
        tick(22);
        btn = 4'b0;
        tick(15);
        expect_snap("hold_release", 3'd2, REP ? 4'h2 : 4'hF, 4'h3, 2'd1, 1'b0);

        // Mid-cycle reset clears outputs without a clock edge
        tick(1);
        #3;
        rst_n = 1'b0;
        #1;
        begin
            snap_t e;
            e.tag = "async_reset"; e.op = 3'd0; e.av = 4'h0; e.bv = 4'h0; e.fs = 2'd0; e.v = 1'b0;
            cmp_snap(e);
        end
        tick(3);
        rst_n = 1'b1;
        tick(5);
        expect_snap("post_reset", 3'd0, 4'h0, 4'h0, 2'd0, 1'b0);

        vectors++;
        if (txn_q.size() != 0) begin
            miscompares++;
            $display("FAIL txn_drain: got %0d pending transfers, want 0", txn_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
